// File: rtl/sprite_dispatcher_if.sv
// rtl/sprite_dispatcher_if.sv - sprite draw queue head/pop bundle between queue and dispatcher
interface sprite_dispatcher_if #(
   parameter int ID_W    = 8,
   parameter int COORD_W = 16,
   parameter int SCALE_W = 8
);
   logic               dequeue;
   logic               is_empty;
   logic [ID_W-1:0]    sprite_id;
   logic [COORD_W-1:0] sprite_x;
   logic [COORD_W-1:0] sprite_y;
   logic [SCALE_W-1:0] sprite_scale;

   // dispatcher side: pops the queue and reads its head
   modport master (
      output dequeue,
      input  is_empty, sprite_id, sprite_x, sprite_y, sprite_scale
   );

   // queue side: presents the head and accepts pops
   modport slave (
      input  dequeue,
      output is_empty, sprite_id, sprite_x, sprite_y, sprite_scale
   );
endinterface

// File: rtl/sprite_dispatcher.sv
// rtl/sprite_dispatcher.sv - round-robin sprite descriptor dispatcher over NUM_CH renderer channels
module sprite_dispatcher #(
   parameter int NUM_CH  = 4,
   parameter int ID_W    = 8,
   parameter int COORD_W = 16,
   parameter int SCALE_W = 8,
   localparam int CNT_W  = $clog2(NUM_CH + 1),
   localparam int RR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                        clock,
   input  logic                        reset,
   sprite_dispatcher_if.master         sprite_queue,
   input  logic                        dispatch_en,
   input  logic                        frame_flush,
   output logic [NUM_CH-1:0]           ch_en,
   output logic [NUM_CH-1:0]           ch_rst,
   output logic [NUM_CH*ID_W-1:0]      ch_id,
   output logic [NUM_CH*COORD_W-1:0]   ch_x,
   output logic [NUM_CH*COORD_W-1:0]   ch_y,
   output logic [NUM_CH*SCALE_W-1:0]   ch_scale,
   input  logic [NUM_CH-1:0]           ch_finished,
   output logic [CNT_W-1:0]            busy_count,
   output logic                        frame_idle
);

   typedef enum logic [1:0] {CH_IDLE, CH_BUSY, CH_RELEASE} ch_state_e;

   ch_state_e                  state_q [NUM_CH];
   ch_state_e                  state_d [NUM_CH];
   logic [NUM_CH-1:0]          en_q, en_d, rst_q, rst_d;
   logic                       deq_q, deq_d;
   logic [RR_W-1:0]            rr_q, rr_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       idle_q, idle_d;
   logic [NUM_CH*ID_W-1:0]     id_q;
   logic [NUM_CH*COORD_W-1:0]  x_q, y_q;
   logic [NUM_CH*SCALE_W-1:0]  scale_q;

   logic                       any_idle, all_idle, dispatch;
   logic [RR_W-1:0]            sel, sel_c;
   int                         cand;

   // pick the first idle channel at or after the round-robin pointer
   always_comb begin
      any_idle = 1'b0;
      all_idle = 1'b1;
      sel      = '0;
      sel_c    = '0;
      cand     = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand  = (int'(rr_q) + i) % NUM_CH;
         sel_c = RR_W'(cand);
         if (!any_idle && state_q[sel_c] == CH_IDLE) begin
            any_idle = 1'b1;
            sel      = sel_c;
         end
         if (state_q[i] != CH_IDLE) all_idle = 1'b0;
      end
      // the head is stale while a pop is in flight, so skip that cycle
      dispatch = !sprite_queue.is_empty && !deq_q && dispatch_en && !frame_flush && any_idle;
   end

   // channel next-state, flush first, then per-channel transitions; status derived from next state
   always_comb begin
      en_d  = '0;
      rst_d = '0;
      cnt_d = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         state_d[k] = state_q[k];
         if (frame_flush) begin
            state_d[k] = CH_RELEASE;
         end else begin
            case (state_q[k])
               CH_IDLE:    if (dispatch && int'(sel) == k) state_d[k] = CH_BUSY;
               CH_BUSY:    if (ch_finished[k]) state_d[k] = CH_RELEASE;
               CH_RELEASE: state_d[k] = CH_IDLE;
               default:    state_d[k] = CH_IDLE;
            endcase
         end
         en_d[k]  = (state_d[k] == CH_BUSY);
         rst_d[k] = (state_d[k] == CH_RELEASE);
         cnt_d    = cnt_d + CNT_W'(en_d[k]);
      end
      deq_d  = dispatch;
      rr_d   = rr_q;
      if (dispatch) rr_d = (int'(sel) == NUM_CH - 1) ? '0 : sel + RR_W'(1);
      idle_d = sprite_queue.is_empty && all_idle && !deq_q && !frame_flush;
   end

   // state, strobe and status registers
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < NUM_CH; k++) state_q[k] <= CH_IDLE;
         en_q   <= '0;
         rst_q  <= '0;
         deq_q  <= 1'b0;
         rr_q   <= '0;
         cnt_q  <= '0;
         idle_q <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) state_q[k] <= state_d[k];
         en_q   <= en_d;
         rst_q  <= rst_d;
         deq_q  <= deq_d;
         rr_q   <= rr_d;
         cnt_q  <= cnt_d;
         idle_q <= idle_d;
      end
   end

   // latch the queue head into the chosen channel; fields persist past finish
   always_ff @(posedge clock) begin
      if (reset) begin
         id_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         scale_q <= '0;
      end else if (dispatch) begin
         id_q[int'(sel)*ID_W +: ID_W]          <= sprite_queue.sprite_id;
         x_q[int'(sel)*COORD_W +: COORD_W]     <= sprite_queue.sprite_x;
         y_q[int'(sel)*COORD_W +: COORD_W]     <= sprite_queue.sprite_y;
         scale_q[int'(sel)*SCALE_W +: SCALE_W] <= sprite_queue.sprite_scale;
      end
   end

   assign sprite_queue.dequeue = deq_q;
   assign ch_en      = en_q;
   assign ch_rst     = rst_q;
   assign ch_id      = id_q;
   assign ch_x       = x_q;
   assign ch_y       = y_q;
   assign ch_scale   = scale_q;
   assign busy_count = cnt_q;
   assign frame_idle = idle_q;

endmodule

// File: doc/sprite_dispatcher.md
Name: sprite_dispatcher

Overview:
- N-channel successor to the two-renderer sprite distributor. It pops sprite descriptors from the sprite draw queue and hands each one to a free sprite_render channel using round-robin allocation.
- Per channel it tracks busy/release state and pulses that renderer's reset when the renderer finishes.
- Adds frame flush, dispatch gating, a busy count and a frame-idle indication.
- Sits between the sprite queue and a parametrised array of sprite_render instances inside the sprite driver.

Parameters:
- NUM_CH, 4, number of sprite_render channels (1..16).
- ID_W, 8, sprite id width.
- COORD_W, 16, x/y coordinate width.
- SCALE_W, 8, scale width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- sprite_queue_dequeue  out  1  one-cycle pop strobe to the queue.
- sprite_queue_is_empty  in  1  queue empty flag.
- sprite_queue_sprite_id  in  ID_W  head-of-queue id.
- sprite_queue_sprite_x  in  COORD_W  head x.
- sprite_queue_sprite_y  in  COORD_W  head y.
- sprite_queue_sprite_scale  in  SCALE_W  head scale.
- dispatch_en  in  1  when low, no new dispatches; in-flight sprites continue.
- frame_flush  in  1  abort all channels (framebuffer clear start).
- ch_en  out  NUM_CH  channel k enable.
- ch_rst  out  NUM_CH  channel k renderer reset pulse.
- ch_id  out  NUM_CH*ID_W  channel k field at [k*ID_W +: ID_W].
- ch_x  out  NUM_CH*COORD_W  channel k field at [k*COORD_W +: COORD_W].
- ch_y  out  NUM_CH*COORD_W  same packing as ch_x.
- ch_scale  out  NUM_CH*SCALE_W  same packing with SCALE_W.
- ch_finished  in  NUM_CH  renderer k done (level).
- busy_count  out  $clog2(NUM_CH+1)  number of channels with ch_en=1.
- frame_idle  out  1  queue empty and all channels idle.

Behaviour:

Reset:
- All outputs are registered.
- Reset values: ch_en=0, ch_rst=0, sprite_queue_dequeue=0, all ch_* fields=0, busy_count=0, frame_idle=0, round-robin pointer rr=0.

Per-channel FSM:
- IDLE (en=0, rst=0) -> BUSY on dispatch.
- BUSY (en=1) -> RELEASE when ch_finished[k] is sampled high while BUSY.
- RELEASE (en=0, rst=1 for exactly one cycle) -> IDLE.
- Only IDLE channels are eligible for dispatch.
- ch_finished is ignored in IDLE and RELEASE.

Dispatch:
- Dispatch occurs in cycle t when all of the following hold: !sprite_queue_is_empty, !sprite_queue_dequeue, dispatch_en, !frame_flush, and at least one channel is IDLE.
- Channel selection: the first IDLE channel scanning k = rr, rr+1, ... modulo NUM_CH.
- At edge t+1:
  - The selected channel's fields latch the queue head.
  - ch_en[k]=1.
  - sprite_queue_dequeue=1 for exactly one cycle.
  - rr=(k+1) mod NUM_CH.
- At most one dispatch per cycle.
- No dispatch in any cycle where sprite_queue_dequeue is high, because the queue head is stale; sustained throughput is therefore one sprite per 2 cycles.

Timing and simultaneous events:
- Earliest redispatch of the same channel: finished sampled at t -> RELEASE at t+1 -> eligible at t+2 -> en=1 at t+3.
- A finish on channel j and a dispatch to a different IDLE channel k in the same cycle both take effect.
- A channel finishing in cycle t is not eligible in cycle t.
- Channel fields hold their value until the next dispatch to that channel; they are not cleared on finish.

frame_flush (priority over dispatch and finish):
- At the next edge: every channel with en=1 or rst=1 goes to RELEASE (en=0, rst=1 for one cycle); IDLE channels also receive a one-cycle rst.
- sprite_queue_dequeue=0 and rr is unchanged.
- Queue contents are not popped.
- frame_flush held high: ch_rst stays high for all channels and no dispatch occurs.
- Normal operation resumes in the cycle after frame_flush falls and all channels are IDLE.

Status outputs:
- busy_count: registered population count of next-state ch_en, so it is consistent with ch_en in the same cycle.
- frame_idle: registered; 1 when queue empty, all channels IDLE, sprite_queue_dequeue=0 and frame_flush=0.

Reset mid-operation:
- Immediate return to the reset state on the next edge.
- No ch_rst pulse is generated; renderers are reset by the system reset.

Test Plan:
- Reset, queue empty, dispatch_en=1 -> frame_idle=1 after 1 cycle; ch_en=0000; no dequeue strobes.
- NUM_CH=4, 6 queued sprites (id 1..6), no finishes -> ids 1,2,3,4 land on ch 0,1,2,3 at cycles 1,3,5,7; exactly 4 dequeue pulses, never back-to-back; busy_count=4; ids 5,6 remain in queue.
- Then pulse ch_finished[2] -> ch_rst[2]=1 for one cycle, ch_en[2]=0; id 5 goes to ch2 exactly 2 cycles after the rst cycle; rr=3 afterwards.
- ch_finished[0] and ch_finished[3] high in the same cycle as a dispatch to ch1 -> both release and the ch1 dispatch completes; busy_count changes by -1 net.
- frame_flush for 1 cycle with 3 busy channels and a non-empty queue -> all ch_rst=1 for one cycle, ch_en=0, no dequeue that cycle; dispatch resumes 2 cycles later starting at the unchanged rr.
- dispatch_en=0 with queue non-empty and all channels idle -> no dequeue and ch_en stays 0; raising dispatch_en -> first dispatch 1 cycle later.
